// File: rtl/user_project_gpio_event_capture_pkg.sv
// Shared definitions for the GPIO event-capture block: Wishbone register
// addresses, STATUS/CTRL/EVENT field positions and the event record layout
// stored in the FIFO ({ts, dir, pin}).
package user_project_gpio_event_capture_pkg;

  localparam int MPRJ_IO_PADS = 38;
  localparam int PIN_W        = 6;
  localparam int TS_MAX_W     = 24;

  localparam logic [31:0] ADDR_MASK_L = 32'h300F_FFD0;
  localparam logic [31:0] ADDR_MASK_H = 32'h300F_FFD4;
  localparam logic [31:0] ADDR_CTRL   = 32'h300F_FFD8;
  localparam logic [31:0] ADDR_STATUS = 32'h300F_FFDC;
  localparam logic [31:0] ADDR_EVENT  = 32'h300F_FFE0;

  localparam int CTRL_RISE_BIT  = 0;
  localparam int CTRL_FALL_BIT  = 1;
  localparam int CTRL_CLEAR_BIT = 2;

  localparam int ST_COUNT_W   = 5;
  localparam int ST_EMPTY_BIT = 5;
  localparam int ST_FULL_BIT  = 6;
  localparam int ST_OVF_BIT   = 7;

  localparam int EV_DIR_BIT = 6;
  localparam int EV_TS_LSB  = 8;

  typedef enum logic [2:0] {
    REG_MASK_L,
    REG_MASK_H,
    REG_CTRL,
    REG_STATUS,
    REG_EVENT,
    REG_NONE
  } reg_sel_e;

  // Event record at full timestamp width; narrower timestamps are zero-extended.
  typedef struct packed {
    logic [TS_MAX_W-1:0] ts;
    logic                dir;
    logic [PIN_W-1:0]    pin;
  } event_t;

  function automatic reg_sel_e decode_addr(input logic [31:0] adr);
    case (adr)
      ADDR_MASK_L: return REG_MASK_L;
      ADDR_MASK_H: return REG_MASK_H;
      ADDR_CTRL:   return REG_CTRL;
      ADDR_STATUS: return REG_STATUS;
      ADDR_EVENT:  return REG_EVENT;
      default:     return REG_NONE;
    endcase
  endfunction

  // EVENT register image: [5:0] pin, [6] dir, [7] 0, [31:8] timestamp.
  function automatic logic [31:0] event_word(input event_t e);
    return {e.ts, 1'b0, e.dir, e.pin};
  endfunction

endpackage

// File: rtl/user_project_gpio_event_capture_fifo.sv
// gpio_event_fifo: synchronous FIFO of event records with a registered head.
// Ports: clk, rst (sync, active-high), push/pop/clear strobes, wdata record in,
// head (oldest entry, 0 when empty), count, full, empty.
// A push while full is accepted only when a pop happens on the same edge.
module gpio_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 31
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // Keep head equal to the entry that will be oldest after this edge.
      if (do_pop && count == (AW+1)'(1))
        head <= do_push ? wdata : '0;
      else if (do_pop)
        head <= mem[rd_nxt];
      else if (do_push && empty)
        head <= wdata;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/user_project_gpio_event_capture.sv
// user_project_gpio_event_capture: samples the user pads, detects masked
// rising/falling edges, and queues timestamped events for Wishbone readout.
// Ports: wb_clk_i/wb_rst_i (sync active-high), Wishbone classic slave
// (wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
// wbs_ack_o, wbs_dat_o), io_in pad inputs, irq (high while events pending).
module user_project_gpio_event_capture
  import user_project_gpio_event_capture_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 24
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic [MPRJ_IO_PADS-1:0] io_in,
  output logic                    irq
);
  localparam int REC_W = TS_WIDTH + 1 + PIN_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [MPRJ_IO_PADS-1:0] s1, s2, s3;
  logic [MPRJ_IO_PADS-1:0] pend_rise, pend_fall;
  logic [MPRJ_IO_PADS-1:0] rise_det, fall_det, clr_rise, clr_fall, push_onehot, mask;
  logic [31:0]             mask_l;
  logic [5:0]              mask_h;
  logic                    rise_en, fall_en, ovf, ovf_set, ovf_clr;
  logic [TS_WIDTH-1:0]     ts_q;

  reg_sel_e                rsel;
  logic                    req, wr, rd, clear, pop;
  logic [31:0]             rdata;

  logic [REC_W-1:0]        head, push_rec;
  logic [CNT_W-1:0]        count;
  logic                    full, empty;
  logic                    any_pend, push_dir, push_ok;
  logic [PIN_W-1:0]        push_pin;
  event_t                  head_evt;

  // Wishbone decode
  assign rsel    = decode_addr(wbs_adr_i);
  assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (rsel != REG_NONE);
  assign wr      = req & wbs_we_i;
  assign rd      = req & ~wbs_we_i;
  assign clear   = wr & (rsel == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_CLEAR_BIT];
  assign ovf_clr = wr & (rsel == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[ST_OVF_BIT];
  assign pop     = rd & (rsel == REG_EVENT) & ~empty;

  // Edge detection on the synchronised s2/s3 pair
  assign mask     = {mask_h, mask_l};
  assign rise_det = s2 & ~s3 & mask & {MPRJ_IO_PADS{rise_en}};
  assign fall_det = ~s2 & s3 & mask & {MPRJ_IO_PADS{fall_en}};
  // A new edge landing on an already-pending bit merges two events into one.
  assign ovf_set  = (|(rise_det & pend_rise)) | (|(fall_det & pend_fall));

  // Push arbiter: lowest pin wins, rise before fall within a pin
  always_comb begin
    any_pend = 1'b0;
    push_pin = '0;
    push_dir = 1'b0;
    for (int p = MPRJ_IO_PADS - 1; p >= 0; p--) begin
      if (pend_rise[p] || pend_fall[p]) begin
        any_pend = 1'b1;
        push_pin = PIN_W'(p);
        push_dir = pend_rise[p];
      end
    end
  end

  assign push_ok     = any_pend & (~full | pop) & ~clear;
  assign push_rec    = {ts_q, push_dir, push_pin};
  assign push_onehot = {{(MPRJ_IO_PADS-1){1'b0}}, 1'b1} << push_pin;
  assign clr_rise    = push_onehot & {MPRJ_IO_PADS{push_ok &  push_dir}};
  assign clr_fall    = push_onehot & {MPRJ_IO_PADS{push_ok & ~push_dir}};

  always_comb begin
    head_evt     = '0;
    head_evt.pin = head[PIN_W-1:0];
    head_evt.dir = head[PIN_W];
    head_evt.ts  = TS_MAX_W'(head[REC_W-1:PIN_W+1]);
  end

  always_comb begin
    rdata = '0;
    case (rsel)
      REG_MASK_L: rdata = mask_l;
      REG_MASK_H: rdata = {26'd0, mask_h};
      REG_CTRL:   rdata = {30'd0, fall_en, rise_en};
      REG_STATUS: rdata = {24'd0, ovf, full, empty, ST_COUNT_W'(count)};
      REG_EVENT:  rdata = empty ? '0 : event_word(head_evt);
      default:    rdata = '0;
    endcase
  end

  // Sync chain, pending state, timestamp and register file
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      pend_rise <= '0;
      pend_fall <= '0;
      ovf       <= 1'b0;
      ts_q      <= '0;
      mask_l    <= '0;
      mask_h    <= '0;
      rise_en   <= 1'b0;
      fall_en   <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      s1        <= io_in;
      s2        <= s1;
      s3        <= s2;
      ts_q      <= ts_q + TS_WIDTH'(1);
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : '0;

      if (wr && rsel == REG_MASK_L) begin
        for (int b = 0; b < 4; b++)
          if (wbs_sel_i[b]) mask_l[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
      end
      if (wr && rsel == REG_MASK_H && wbs_sel_i[0]) mask_h <= wbs_dat_i[5:0];
      if (wr && rsel == REG_CTRL && wbs_sel_i[0]) begin
        rise_en <= wbs_dat_i[CTRL_RISE_BIT];
        fall_en <= wbs_dat_i[CTRL_FALL_BIT];
      end

      if (clear) begin
        pend_rise <= '0;
        pend_fall <= '0;
        ovf       <= 1'b0;
      end else begin
        pend_rise <= (pend_rise & ~clr_rise) | rise_det;
        pend_fall <= (pend_fall & ~clr_fall) | fall_det;
        if (ovf_set)      ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
      end
    end
  end

  gpio_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push_ok),
    .pop   (pop),
    .clear (clear),
    .wdata (push_rec),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign irq = ~empty;

endmodule

// File: tb/tb_user_project_gpio_event_capture.sv
`timescale 1ns/1ps
module tb_user_project_gpio_event_capture;

  localparam logic [31:0] A_MASK_L = 32'h300F_FFD0;
  localparam logic [31:0] A_MASK_H = 32'h300F_FFD4;
  localparam logic [31:0] A_CTRL   = 32'h300F_FFD8;
  localparam logic [31:0] A_STATUS = 32'h300F_FFDC;
  localparam logic [31:0] A_EVENT  = 32'h300F_FFE0;
  localparam logic [31:0] A_UNMAP  = 32'h300F_FFE4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w, dat_r;
  logic        ack, irq;
  logic [37:0] io_in;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] tb_ts;
  logic [31:0] exp_q[$];
  logic [31:0] rd;
  logic [31:0] exp;

  user_project_gpio_event_capture #(.FIFO_DEPTH(8), .TS_WIDTH(24)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_w),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_r),
    .io_in     (io_in),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference free-running timestamp: zero on reset, +1 per clock.
  always @(posedge clk) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 24'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ev(input int pin, input logic dir, input logic [23:0] ts);
    return {ts, 1'b0, dir, 6'(pin)};
  endfunction

  // Bus tasks start and end on a negedge with the bus idle.
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ack @%h: ack=%b required 1", a, ack);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL read_ack @%h: ack=%b required 1", a, ack);
      d = 'x;
    end else begin
      d = dat_r;
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic flush_events();
    io_in = '0;
    repeat (8) @(negedge clk);
    wb_write(A_CTRL, 32'h7, 4'h1);
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] addrs [5];
    logic [31:0] exps  [5];
    addrs = '{A_MASK_L, A_MASK_H, A_CTRL, A_STATUS, A_EVENT};
    exps  = '{32'h0, 32'h0, 32'h0, 32'h20, 32'h0};
    n_checks++;
    if (ack !== 1'b0 || dat_r !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b dat=%h irq=%b required 0/0/0", ack, dat_r, irq);
    end
    for (int i = 0; i < 5; i++) begin
      wb_read(addrs[i], rd);
      n_checks++;
      if (rd !== exps[i]) begin
        n_fail++;
        $display("FAIL reset_reg[%0d]: got %h required %h", i, rd, exps[i]);
      end
    end
    io_in = '1;
    repeat (6) @(negedge clk);
    io_in = '0;
    repeat (6) @(negedge clk);
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h20 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL masked_toggle: status=%h irq=%b required 00000020/0", rd, irq);
    end
    wb_write(A_MASK_L, 32'hFFFF_FFFF, 4'b0010);
    wb_read(A_MASK_L, rd);
    n_checks++;
    if (rd !== 32'h0000_FF00) begin
      n_fail++;
      $display("FAIL mask_l_bytesel: got %h required 0000ff00", rd);
    end
    wb_write(A_MASK_H, 32'hFFFF_FFFF, 4'hF);
    wb_read(A_MASK_H, rd);
    n_checks++;
    if (rd !== 32'h3F) begin
      n_fail++;
      $display("FAIL mask_h_width: got %h required 0000003f", rd);
    end
    wb_write(A_CTRL, 32'h7, 4'h1);
    wb_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h3) begin
      n_fail++;
      $display("FAIL ctrl_readback: got %h required 00000003", rd);
    end
    wb_write(A_MASK_L, 32'h0, 4'hF);
    wb_write(A_MASK_H, 32'h0, 4'hF);
    wb_write(A_CTRL, 32'h0, 4'h1);
  endtask

  task automatic test_single_rise();
    logic [23:0] t0;
    wb_write(A_MASK_L, 32'h1, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'h1);
    t0 = tb_ts;
    io_in[0] = 1'b1;
    exp_q.push_back(ev(0, 1'b1, t0 + 24'd3));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (irq !== (k == 3)) begin
        n_fail++;
        $display("FAIL irq_latency edge%0d: irq=%b required %b", k, irq, (k == 3));
      end
    end
    wb_read(A_EVENT, rd);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) begin
      n_fail++;
      $display("FAIL single_event: got %h required %h", rd, exp);
    end
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h20 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drained: status=%h irq=%b required 00000020/0", rd, irq);
    end
    io_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h20) begin
      n_fail++;
      $display("FAIL fall_disabled: status=%h required 00000020", rd);
    end
  endtask

  task automatic test_priority();
    logic [23:0] t0;
    wb_write(A_MASK_L, 32'hFFFF_FFFF, 4'hF);
    wb_write(A_MASK_H, 32'h3F, 4'hF);
    wb_write(A_CTRL, 32'h3, 4'h1);
    t0 = tb_ts;
    io_in[37] = 1'b1; io_in[5] = 1'b1; io_in[0] = 1'b1;
    exp_q.push_back(ev(0,  1'b1, t0 + 24'd3));
    exp_q.push_back(ev(5,  1'b1, t0 + 24'd4));
    exp_q.push_back(ev(37, 1'b1, t0 + 24'd5));
    repeat (6) @(negedge clk);
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h03) begin
      n_fail++;
      $display("FAIL priority_count: status=%h required 00000003", rd);
    end
    for (int i = 0; i < 3; i++) begin
      wb_read(A_EVENT, rd);
      exp = exp_q.pop_front();
      n_checks++;
      if (rd !== exp) begin
        n_fail++;
        $display("FAIL priority_event[%0d]: got %h required %h", i, rd, exp);
      end
    end
    flush_events();
  endtask

  task automatic test_full_overflow();
    logic [23:0] t0;
    logic [23:0] t1;
    t0 = tb_ts;
    io_in[9:1] = '1;
    for (int p = 1; p <= 8; p++) exp_q.push_back(ev(p, 1'b1, t0 + 24'(2 + p)));
    repeat (14) @(negedge clk);
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h48 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL full_status: status=%h irq=%b required 00000048/1", rd, irq);
    end
    // Pin 9 is held pending and enters on the pop that frees a slot.
    t1 = tb_ts;
    wb_read(A_EVENT, rd);
    exp_q.push_back(ev(9, 1'b1, t1));
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) begin
      n_fail++;
      $display("FAIL full_first_pop: got %h required %h", rd, exp);
    end
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h48) begin
      n_fail++;
      $display("FAIL refill_status: status=%h required 00000048", rd);
    end
    io_in[10] = 1'b1; repeat (3) @(negedge clk);
    io_in[10] = 1'b0; repeat (3) @(negedge clk);
    io_in[10] = 1'b1; repeat (4) @(negedge clk);
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'hC8) begin
      n_fail++;
      $display("FAIL merge_overflow: status=%h required 000000c8", rd);
    end
    wb_write(A_STATUS, 32'h80, 4'h1);
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h48) begin
      n_fail++;
      $display("FAIL overflow_clear: status=%h required 00000048", rd);
    end
    // Drain: pin 10 rise then fall refill the first two freed slots.
    for (int i = 0; i < 10; i++) begin
      if (i == 0) exp_q.push_back(ev(10, 1'b1, tb_ts));
      if (i == 1) exp_q.push_back(ev(10, 1'b0, tb_ts));
      wb_read(A_EVENT, rd);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
      n_checks++;
      if (rd !== exp) begin
        n_fail++;
        $display("FAIL drain_event[%0d]: got %h required %h", i, rd, exp);
      end
    end
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h20 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL drained_status: status=%h irq=%b required 00000020/0", rd, irq);
    end
    flush_events();
  endtask

  task automatic test_empty_and_unmapped();
    wb_read(A_EVENT, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL empty_event: got %h required 00000000", rd);
    end
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h20) begin
      n_fail++;
      $display("FAIL empty_status: status=%h required 00000020", rd);
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_UNMAP; sel = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b0) begin
        n_fail++;
        $display("FAIL unmapped_ack cycle%0d: ack=%b required 0", k, ack);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear_and_reset();
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    addrs = '{A_MASK_L, A_CTRL, A_STATUS};
    exps  = '{32'h0, 32'h0, 32'h20};
    io_in[13:11] = '1;
    repeat (7) @(negedge clk);
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h03 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL queued_three: status=%h irq=%b required 00000003/1", rd, irq);
    end
    wb_write(A_CTRL, 32'h7, 4'h1);
    exp_q.delete();
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h20 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_fifo: status=%h irq=%b required 00000020/0", rd, irq);
    end
    io_in[14] = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL post_clear_event: irq=%b required 1", irq);
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STATUS; sel = 4'hF;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (ack !== 1'b0 || dat_r !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_read: ack=%b dat=%h irq=%b required 0/0/0", ack, dat_r, irq);
    end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    exp_q.delete();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wb_read(addrs[i], rd);
      n_checks++;
      if (rd !== exps[i]) begin
        n_fail++;
        $display("FAIL after_reset_reg[%0d]: got %h required %h", i, rd, exps[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; adr = '0; dat_w = '0; io_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_rise();
    test_priority();
    test_full_overflow();
    test_empty_and_unmapped();
    test_clear_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
